pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder; successor to the 4-bit CLA.
//  - Operand split into PIPE_STAGES segments; one segment resolved per stage.
//  - Each segment: 4-bit lookahead groups + group-level lookahead; carry is registered between stages.
//  - valid/ready stream handshake on both sides; sits in datapath ALU and accumulator paths.

---
 rtl/pipelined_cla_adder.sv | 172 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Segmented carry-lookahead adder, one SW-bit segment resolved per stage.
// Define PCLA_SUB_EN to add the 'sub' port (A-B mode).
module pipelined_cla_adder #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef PCLA_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / PIPE_STAGES;
  localparam int NG = SW / 4;
  localparam int LS = PIPE_STAGES - 1;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [SW:0] seg_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          c0
  );
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic [SW:0]   c;
    p  = x ^ y;
    g  = x & y;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    gc[0] = c0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (&p[4*j+2 +: 2] & g[4*j+1])
            | (&p[4*j+1 +: 3] & g[4*j]);
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int i = 0; i < 3; i++) begin
        c[4*j+i+1] = g[4*j+i]
                   | (p[4*j+i] & c[4*j+i]);
      end
    end
    c[SW] = gc[NG];
    return {c[SW], p ^ c[SW-1:0]};
  endfunction

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stg
    // Operand bits still unresolved on entry to this stage
    localparam int OW = WIDTH - k * SW;

    logic [OW-1:0]       oa;
    logic [OW-1:0]       ob;
    logic                ci;
    logic                vi;
    logic [SW-1:0]       sb;
    logic [SW:0]         r;
    logic [(k+1)*SW-1:0] res_d;
    logic [(k+1)*SW-1:0] res_q;
    logic                v_q;
    logic                c_q;
`ifdef PCLA_SUB_EN
    logic                si;
`endif

    if (k == 0) begin : g_in
      assign oa    = a;
      assign ob    = b;
      assign vi    = in_valid;
`ifdef PCLA_SUB_EN
      assign si    = sub;
      assign ci    = sub | cin;
`else
      assign ci    = cin;
`endif
      assign res_d = r[SW-1:0];
    end else begin : g_in
      assign oa    = g_stg[k-1].g_sk.oa_q;
      assign ob    = g_stg[k-1].g_sk.ob_q;
      assign vi    = g_stg[k-1].v_q;
      assign ci    = g_stg[k-1].c_q;
`ifdef PCLA_SUB_EN
      assign si    = g_stg[k-1].g_sk.s_q;
`endif
      assign res_d = {r[SW-1:0], g_stg[k-1].res_q};
    end

`ifdef PCLA_SUB_EN
    assign sb = si ? ~ob[SW-1:0] : ob[SW-1:0];
`else
    assign sb = ob[SW-1:0];
`endif
    assign r = seg_add(oa[SW-1:0], sb, ci);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= vi;
        c_q   <= r[SW];
        res_q <= res_d;
      end
    end

    if (k < LS) begin : g_sk
      logic [OW-SW-1:0] oa_q;
      logic [OW-SW-1:0] ob_q;
`ifdef PCLA_SUB_EN
      logic             s_q;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          oa_q <= '0;
          ob_q <= '0;
`ifdef PCLA_SUB_EN
          s_q  <= 1'b0;
`endif
        end else if (adv) begin
          oa_q <= oa[OW-1:SW];
          ob_q <= ob[OW-1:SW];
`ifdef PCLA_SUB_EN
          s_q  <= si;
`endif
        end
      end
    end

    if (k == LS) begin : g_ov
      logic cm;
      logic ovf_q;
      // Carry into the MSB recovered from sum ^ a ^ b at that bit
      assign cm = r[SW-1] ^ oa[SW-1] ^ sb[SW-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cm ^ r[SW];
        end
      end
    end
  end

  assign out_valid = g_stg[LS].v_q;
  assign sum       = g_stg[LS].res_q;
  assign cout      = g_stg[LS].c_q;
  assign ovf       = g_stg[LS].g_ov.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: vector table, stall/reset sequences,
// and randomized traffic against an arithmetic scoreboard.
module tb_pipelined_cla_adder;

  localparam int W     = 32;
  localparam int S     = 4;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;

  logic [W+1:0] exp_q[$];
  vec_t         tbl[$];

  pipelined_cla_adder #(
    .WIDTH       (W),
    .PIPE_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef PCLA_SUB_EN
    .sub       (sub_i),
`endif
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c,
    input logic         s
  );
    logic [W:0]   t;
    logic [W-1:0] yy;
    logic         cc;
    logic         o;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], o, t[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: t = '1;
      1: t = '0;
      2: t = 64'(1) << (W - 1);
      3: t = (64'(1) << (W - 1)) - 64'(1);
      default: ;
    endcase
    return t[W-1:0];
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [W+1:0] act,
                         input logic [W+1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cout,ovf,sum}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard sample mid-cycle, then advance one clock
  task automatic cycle();
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got beat sum=%h expected no beat", sum);
        end else begin
          chk_res("sb_beat", {cout, ovf, sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
        n_push++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    a_i   = rnd_op();
    b_i   = rnd_op();
    cin_i = 1'($urandom_range(0, 1));
`ifdef PCLA_SUB_EN
    sub_i = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic one_beat(input vec_t v);
    a_i       = v.a;
    b_i       = v.b;
    cin_i     = v.c;
    sub_i     = v.s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 1; i < S; i++) begin
      chk_bit("lat_early", out_valid, 1'b0);
      cycle();
    end
    chk_bit("lat_valid", out_valid, 1'b1);
    chk_res("vec", {cout, ovf, sum}, {v.co, v.ov, v.sum});
    cycle();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) cycle();
    chk_int("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int start;
    int cyc;

    tbl.push_back('{32'h5, 32'h7, 1'b0, 1'b0, 32'hC, 1'b0, 1'b0});
    tbl.push_back('{32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                    32'h8000_0000, 1'b0, 1'b1});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                    32'h0, 1'b1, 1'b1});
    tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
                    32'hFFFF_FFFF, 1'b1, 1'b0});
    tbl.push_back('{32'h0000_FFFF, 32'h1, 1'b0, 1'b0,
                    32'h0001_0000, 1'b0, 1'b0});
    tbl.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0,
                    32'h9999_9999, 1'b0, 1'b0});
    tbl.push_back('{32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0,
                    32'h8000_0000, 1'b0, 1'b1});
`ifdef PCLA_SUB_EN
    tbl.push_back('{32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    tbl.push_back('{32'h5, 32'h3, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'h1, 1'b1, 1'b1,
                    32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sub_i     = 1'b0;
    a_i       = '0;
    b_i       = '0;
    cin_i     = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;

    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_res("rst_outputs", {cout, ovf, sum}, '0);
    chk_bit("rst_in_ready", in_ready, 1'b1);

    foreach (tbl[i]) one_beat(tbl[i]);

    // Back-to-back stream with a 3-cycle downstream stall
    for (int i = 0; i < 14; i++) begin
      in_valid  = (i < 10);
      out_ready = !(i >= 6 && i < 9);
      rnd_in();
      #1;
      if (!out_ready && out_valid)
        chk_bit("stall_in_ready", in_ready, 1'b0);
      cycle();
    end
    drain();

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rnd_in();
      cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    chk_bit("rst_flush", out_valid, 1'b0);
    one_beat(tbl[0]);

    // Random traffic with random backpressure
    start = n_push;
    cyc   = 0;
    while ((n_push - start) < NRAND && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      rnd_in();
      cycle();
      cyc++;
    end
    chk_int("rand_beats", n_push - start, NRAND);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
